// File: rtl/clock_core.sv
// rtl/clock_core.sv - settable 12/24-hour BCD time-of-day core with set-mode FSM and display blanking
module clock_core #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iMode12,
    input  logic       iSetBtn,
    input  logic       iIncBtn,
    output logic [3:0] oHourT,
    output logic [3:0] oHourU,
    output logic [3:0] oMinT,
    output logic [3:0] oMinU,
    output logic [3:0] oSecT,
    output logic [3:0] oSecU,
    output logic       oPm,
    output logic [5:0] oBlank,
    output logic [1:0] oMode,
    output logic       oSecStrb
);

    localparam int              CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(TICK_DIV / 2 - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          strb_q, strb_d;
    logic [3:0]    hr_t_q, hr_u_q, hr_t_d, hr_u_d;
    logic [3:0]    mn_t_q, mn_u_q, mn_t_d, mn_u_d;
    logic [3:0]    sc_t_q, sc_u_q, sc_t_d, sc_u_d;
    logic          tick;

    // Increment a 00..59 BCD pair, wrapping to 00.
    function automatic logic [7:0] inc_bcd60(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if (u == 4'd9) begin
            r = (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
        end else begin
            r = {t, u + 4'd1};
        end
        return r;
    endfunction

    // Increment a 00..23 BCD pair, wrapping to 00.
    function automatic logic [7:0] inc_bcd24(input logic [3:0] t, input logic [3:0] u);
        logic [7:0] r;
        if ({t, u} == 8'h23) begin
            r = 8'h00;
        end else if (u == 4'd9) begin
            r = {t + 4'd1, 4'd0};
        end else begin
            r = {t, u + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            strb_q  <= 1'b0;
            hr_t_q  <= 4'd0;
            hr_u_q  <= 4'd0;
            mn_t_q  <= 4'd0;
            mn_u_q  <= 4'd0;
            sc_t_q  <= 4'd0;
            sc_u_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            strb_q  <= strb_d;
            hr_t_q  <= hr_t_d;
            hr_u_q  <= hr_u_d;
            mn_t_q  <= mn_t_d;
            mn_u_q  <= mn_u_d;
            sc_t_q  <= sc_t_d;
            sc_u_q  <= sc_u_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iSetBtn) begin
            case (state_q)
                S_RUN:     state_d = S_SET_HR;
                S_SET_HR:  state_d = S_SET_MIN;
                default:   state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        strb_d  = 1'b0;
        tick    = 1'b0;
        hr_t_d  = hr_t_q;
        hr_u_d  = hr_u_q;
        mn_t_d  = mn_t_q;
        mn_u_d  = mn_u_q;
        sc_t_d  = sc_t_q;
        sc_u_d  = sc_u_q;

        // Blink runs at one full period per tick in every state.
        if (cnt_q == CNT_HALF || (state_q == S_RUN && cnt_q == CNT_LAST)) begin
            blink_d = ~blink_q;
        end

        // Outside RUN the prescaler only counts half periods to keep the blink alive.
        if (state_q == S_RUN) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = ~iSetBtn;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = (cnt_q >= CNT_HALF) ? '0 : cnt_q + CNT_ONE;
        end

        if (iSetBtn) begin
            if (state_q == S_RUN) begin
                cnt_d  = '0;
                sc_t_d = 4'd0;
                sc_u_d = 4'd0;
            end else if (state_q != S_SET_HR) begin
                cnt_d = '0;
            end
        end else if (iIncBtn) begin
            if (state_q == S_SET_HR) begin
                {hr_t_d, hr_u_d} = inc_bcd24(hr_t_q, hr_u_q);
            end else if (state_q == S_SET_MIN) begin
                {mn_t_d, mn_u_d} = inc_bcd60(mn_t_q, mn_u_q);
            end
        end

        if (tick) begin
            strb_d = 1'b1;
            {sc_t_d, sc_u_d} = inc_bcd60(sc_t_q, sc_u_q);
            if ({sc_t_q, sc_u_q} == 8'h59) begin
                {mn_t_d, mn_u_d} = inc_bcd60(mn_t_q, mn_u_q);
                if ({mn_t_q, mn_u_q} == 8'h59) begin
                    {hr_t_d, hr_u_d} = inc_bcd24(hr_t_q, hr_u_q);
                end
            end
        end
    end

    logic [4:0] hr_bin;
    logic [4:0] disp_bin;
    logic       supp;

    assign hr_bin = 5'(hr_t_q) * 5'd10 + 5'(hr_u_q);

    always_comb begin
        disp_bin = hr_bin;
        if (hr_bin == 5'd0) begin
            disp_bin = 5'd12;
        end else if (hr_bin > 5'd12) begin
            disp_bin = hr_bin - 5'd12;
        end
    end

    always_comb begin
        oHourT = hr_t_q;
        oHourU = hr_u_q;
        supp   = 1'b0;
        if (iMode12) begin
            if (disp_bin >= 5'd10) begin
                oHourT = 4'd1;
                oHourU = 4'(disp_bin - 5'd10);
            end else begin
                oHourT = 4'd0;
                oHourU = 4'(disp_bin);
                supp   = 1'b1;
            end
        end
    end

    always_comb begin
        oBlank    = {supp, 5'b0};
        if (blink_q && state_q == S_SET_HR) begin
            oBlank[5:4] = 2'b11;
        end
        if (blink_q && state_q == S_SET_MIN) begin
            oBlank[3:2] = 2'b11;
        end
    end

    assign oMinT    = mn_t_q;
    assign oMinU    = mn_u_q;
    assign oSecT    = sc_t_q;
    assign oSecU    = sc_u_q;
    assign oPm      = (hr_bin >= 5'd12);
    assign oMode    = state_q;
    assign oSecStrb = strb_q;

endmodule
